// File: rtl/launchpad_event_sched_if.sv
// Bus between the button bank, the event scheduler and the segment pattern logic.
// master: the scheduler side (drives grant/animation outputs); slave: the consumer side.
interface launchpad_event_sched_if #(
  parameter int NUM_EVT = 8
);
  logic [NUM_EVT-1:0] button_inp;
  logic [NUM_EVT-1:0] grant;
  logic [2:0]         evt_sel;
  logic               evt_active;
  logic [2:0]         frame_idx;
  logic [7:0]         digit_en;
  logic               busy;
  logic               start_pls;
  logic               done_pls;

  modport master (
    input  button_inp,
    output grant, evt_sel, evt_active, frame_idx, digit_en, busy, start_pls, done_pls
  );

  modport slave (
    output button_inp,
    input  grant, evt_sel, evt_active, frame_idx, digit_en, busy, start_pls, done_pls
  );
endinterface

// File: rtl/launchpad_event_sched.sv
// Round-robin scheduler turning button presses into timed seven-segment frame animations.
// Optional macro EVT_PREEMPT_EN: a pending request for another event aborts PLAY at a frame boundary.
module launchpad_event_sched #(
  parameter int NUM_EVT    = 8,
  parameter int FRAME_CYC  = 4,
  parameter int NUM_FRAMES = 8,
  parameter int GAP_CYC    = 2
) (
  input logic                     clk,
  input logic                     rst,
  launchpad_event_sched_if.master bus
);

  localparam int IW   = $clog2(NUM_EVT);
  localparam int FT_W = (FRAME_CYC > 1) ? $clog2(FRAME_CYC) : 1;
  localparam int GT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [FT_W-1:0] FT_LAST = FT_W'(FRAME_CYC - 1);
  localparam logic [GT_W-1:0] GT_LAST = GT_W'(GAP_CYC - 1);
  localparam logic [2:0]      FR_LAST = 3'(NUM_FRAMES - 1);
  localparam logic [IW-1:0]   LG_RST  = IW'(NUM_EVT - 1);

  typedef enum logic [1:0] {IDLE, ARB, PLAY, GAP} state_t;

  state_t             state;
  logic [NUM_EVT-1:0] btn_q;
  logic [NUM_EVT-1:0] pend;
  logic [IW-1:0]      last_grant;
  logic [FT_W-1:0]    frame_tmr;
  logic [GT_W-1:0]    gap_tmr;
  logic [NUM_EVT-1:0] grant;
  logic [2:0]         evt_sel;
  logic               evt_active;
  logic [2:0]         frame_idx;
  logic [7:0]         digit_en;
  logic               busy;
  logic               start_pls;
  logic               done_pls;

  logic [NUM_EVT-1:0] rise;
  logic [IW-1:0]      arb_sel;
  logic               arb_hit;
  logic [NUM_EVT-1:0] arb_onehot;

  // Left-to-right digit fill; the final frame always lights the whole bank.
  function automatic logic [7:0] fill_mask(input logic [2:0] idx);
    logic [7:0] m;
    for (int i = 0; i < 8; i++) m[i] = (3'(i) <= idx) || (idx == FR_LAST);
    return m;
  endfunction

  assign rise = bus.button_inp & ~btn_q;

  // Scan downward so the last hit kept is the nearest one after last_grant.
  always_comb begin
    arb_sel = last_grant;
    arb_hit = 1'b0;
    for (int k = NUM_EVT; k >= 1; k--) begin
      if (pend[IW'((int'(last_grant) + k) % NUM_EVT)]) begin
        arb_sel = IW'((int'(last_grant) + k) % NUM_EVT);
        arb_hit = 1'b1;
      end
    end
  end

  assign arb_onehot = NUM_EVT'(1) << arb_sel;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      btn_q      <= '0;
      pend       <= '0;
      last_grant <= LG_RST;
      frame_tmr  <= '0;
      gap_tmr    <= '0;
      grant      <= '0;
      evt_sel    <= '0;
      evt_active <= 1'b0;
      frame_idx  <= '0;
      digit_en   <= '0;
      busy       <= 1'b0;
      start_pls  <= 1'b0;
      done_pls   <= 1'b0;
    end else begin
      btn_q     <= bus.button_inp;
      pend      <= pend | rise;
      start_pls <= 1'b0;
      done_pls  <= 1'b0;
      case (state)
        IDLE: begin
          if (|pend) begin
            state <= ARB;
            busy  <= 1'b1;
          end
        end
        ARB: begin
          if (arb_hit) begin
            state      <= PLAY;
            evt_sel    <= 3'(arb_sel);
            grant      <= arb_onehot;
            last_grant <= arb_sel;
            // A fresh rise on the granted button in this cycle keeps it queued.
            pend       <= (pend & ~arb_onehot) | rise;
            frame_tmr  <= '0;
            frame_idx  <= '0;
            digit_en   <= fill_mask(3'd0);
            evt_active <= 1'b1;
            start_pls  <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        PLAY: begin
          if (frame_tmr != FT_LAST) begin
            frame_tmr <= frame_tmr + FT_W'(1);
          end else begin
            frame_tmr <= '0;
`ifdef EVT_PREEMPT_EN
            if (|(pend & ~grant)) begin
              state      <= ARB;
              grant      <= '0;
              evt_active <= 1'b0;
              frame_idx  <= '0;
              digit_en   <= '0;
            end else
`endif
            if (frame_idx == FR_LAST) begin
              state      <= GAP;
              grant      <= '0;
              evt_active <= 1'b0;
              frame_idx  <= '0;
              digit_en   <= '0;
              gap_tmr    <= '0;
              done_pls   <= (GAP_CYC == 1);
            end else begin
              frame_idx <= frame_idx + 3'd1;
              digit_en  <= fill_mask(frame_idx + 3'd1);
            end
          end
        end
        GAP: begin
          if (gap_tmr == GT_LAST) begin
            state   <= IDLE;
            busy    <= 1'b0;
            gap_tmr <= '0;
          end else begin
            gap_tmr  <= gap_tmr + GT_W'(1);
            done_pls <= ((gap_tmr + GT_W'(1)) == GT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.grant      = grant;
  assign bus.evt_sel    = evt_sel;
  assign bus.evt_active = evt_active;
  assign bus.frame_idx  = frame_idx;
  assign bus.digit_en   = digit_en;
  assign bus.busy       = busy;
  assign bus.start_pls  = start_pls;
  assign bus.done_pls   = done_pls;

endmodule

// File: tb/tb_launchpad_event_sched.sv
// Scoreboard bench for launchpad_event_sched: expected events queued at press time,
// checked against start/frame/gap behaviour as the scheduler plays them.
module tb_launchpad_event_sched;

  localparam int NUM_EVT    = 8;
  localparam int FRAME_CYC  = 4;
  localparam int NUM_FRAMES = 8;
  localparam int GAP_CYC    = 2;
  localparam int PLAY_LEN   = NUM_FRAMES * FRAME_CYC;
  localparam int BACK2BACK  = GAP_CYC + 2;
`ifdef EVT_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  typedef struct {
    int evt;
    int len;
    int gap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  launchpad_event_sched_if #(.NUM_EVT(NUM_EVT)) bus ();

  launchpad_event_sched #(
    .NUM_EVT(NUM_EVT), .FRAME_CYC(FRAME_CYC), .NUM_FRAMES(NUM_FRAMES), .GAP_CYC(GAP_CYC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  int   done_cnt = 0;
  int   play_cnt = 0;
  int   inactive_run = 0;
  bit   prev_active = 1'b0;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  function automatic int exp_fill(input int f);
    if (f >= NUM_FRAMES - 1) return 255;
    return (1 << (f + 1)) - 1;
  endfunction

  function automatic int all_outs();
    return int'({bus.grant, bus.evt_sel, bus.evt_active, bus.frame_idx,
                 bus.digit_en, bus.busy, bus.start_pls, bus.done_pls});
  endfunction

  // Monitor: pops an expectation at each start and follows the event through PLAY and GAP.
  always @(negedge clk) begin
    if (!rst) begin
      prev_active  = 1'b0;
      inactive_run = 0;
      play_cnt     = 0;
    end else begin
      if (bus.start_pls) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_start", int'(bus.evt_sel), -1);
        end else begin
          cur = exp_q.pop_front();
          check_eq("evt_sel", int'(bus.evt_sel), cur.evt);
          check_eq("grant", int'(bus.grant), 1 << cur.evt);
          if (cur.gap >= 0) check_eq("gap_before", inactive_run, cur.gap);
        end
        play_cnt = 0;
      end
      if (bus.evt_active) begin
        check_eq("frame_idx", int'(bus.frame_idx), play_cnt / FRAME_CYC);
        check_eq("digit_en", int'(bus.digit_en), exp_fill(play_cnt / FRAME_CYC));
        play_cnt++;
        inactive_run = 0;
      end else begin
        if (prev_active) check_eq("play_len", play_cnt, cur.len);
        inactive_run++;
        check_eq("idle_outs", int'({bus.grant, bus.frame_idx, bus.digit_en}), 0);
        if (bus.done_pls) begin
          check_eq("done_pos", inactive_run, GAP_CYC);
          done_cnt++;
        end
      end
      prev_active = bus.evt_active;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int evt, input int len, input int gap);
    exp_t e;
    e.evt = evt; e.len = len; e.gap = gap;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!(exp_q.size() == 0 && !bus.busy) && n < budget);
    check_eq("idle_reached", int'(exp_q.size() == 0 && !bus.busy), 1);
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    do begin
      tick(1);
      n++;
    end while (!bus.start_pls && n < budget);
    check_eq("start_seen", int'(bus.start_pls), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      bus.button_inp = NUM_EVT'($urandom);
      tick(1);
      check_eq("reset_outs", all_outs(), 0);
    end
    bus.button_inp = '0;
    tick(1);
    rst = 1'b1;
    tick(1);
  endtask

  int d0;

  initial begin
    bus.button_inp = '0;
    tick(1);

    // Reset with buttons toggling, then first press of button 0.
    do_reset();
    bus.button_inp = 8'h01; push(0, PLAY_LEN, -1);
    tick(1);
    bus.button_inp = '0;
    d0 = done_cnt;
    wait_idle(200);
    check_eq("done_cnt_first", done_cnt - d0, 1);

    // Single press of button 2 with latency checks.
    bus.button_inp = 8'h04; push(2, PLAY_LEN, -1);
    tick(1);
    bus.button_inp = '0;
    check_eq("lat_t0_start", int'(bus.start_pls), 0);
    tick(1);
    check_eq("arb_busy", int'(bus.busy), 1);
    check_eq("lat_t1_start", int'(bus.start_pls), 0);
    tick(1);
    check_eq("lat_t2_start", int'(bus.start_pls), 1);
    check_eq("lat_t2_active", int'(bus.evt_active), 1);
    d0 = done_cnt;
    wait_idle(200);
    check_eq("busy_after", int'(bus.busy), 0);
    check_eq("done_cnt_single", done_cnt - d0, 1);

    // Held button 5: one event only.
    bus.button_inp = 8'h20; push(5, PLAY_LEN, -1);
    d0 = done_cnt;
    tick(100);
    bus.button_inp = '0;
    wait_idle(200);
    check_eq("done_cnt_held", done_cnt - d0, 1);

    // Round robin from last_grant = NUM_EVT-1.
    do_reset();
    bus.button_inp = 8'h4A;
    push(1, PLAY_LEN, -1); push(3, PLAY_LEN, BACK2BACK); push(6, PLAY_LEN, BACK2BACK);
    tick(1);
    bus.button_inp = '0;
    d0 = done_cnt;
    wait_idle(400);
    check_eq("done_cnt_rr", done_cnt - d0, 3);

    // Button 4 rises again during the ARB cycle that grants it.
    push(4, PLAY_LEN, -1); push(4, PLAY_LEN, BACK2BACK);
    bus.button_inp = 8'h10;
    tick(1);
    bus.button_inp = '0;
    tick(1);
    bus.button_inp = 8'h10;
    tick(1);
    bus.button_inp = '0;
    d0 = done_cnt;
    wait_idle(300);
    check_eq("done_cnt_retrig", done_cnt - d0, 2);

    // Reset mid-event with a request pending: everything is dropped.
    bus.button_inp = 8'h02; push(1, PLAY_LEN, -1);
    tick(1);
    bus.button_inp = '0;
    wait_start(10);
    tick(5);
    bus.button_inp = 8'h08;
    tick(1);
    bus.button_inp = '0;
    #2 rst = 1'b0;
    exp_q.delete();
    #1 check_eq("async_reset_outs", all_outs(), 0);
    tick(2);
    rst = 1'b1;
    tick(12);
    check_eq("pend_lost_busy", int'(bus.busy), 0);

    // Button 7 rises during frame 2 of event 0.
    bus.button_inp = 8'h01; push(0, PRE ? 3 * FRAME_CYC : PLAY_LEN, -1);
    tick(1);
    bus.button_inp = '0;
    d0 = done_cnt;
    wait_start(10);
    tick(2 * FRAME_CYC);
    bus.button_inp = 8'h80; push(7, PLAY_LEN, PRE ? 1 : BACK2BACK);
    tick(1);
    bus.button_inp = '0;
    wait_idle(300);
    check_eq("done_cnt_preempt", done_cnt - d0, PRE ? 1 : 2);

    tick(3);
    check_eq("queue_empty_end", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
